led_event_sched: RTL and testbench

Scheduler that shares the single timed LED indicator between several game-event requesters (e.g. player win, dealer win, push, bust). Each requester fires a one-cycle pulse. The block latches it as pending, then shows the events one at a time on a one-hot LED bus for a fixed hold time, with an optional dark gap between them. It sits between the game FSM and the board LEDs, and its internal hold counter replaces per-event free-running timers.

---
 rtl/led_event_sched.sv | 175 +++++++++++++++++
 tb/tb_led_event_sched.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_event_sched.sv
// led_event_sched: latches one-cycle event pulses as pending bits and shows them one at a time on a one-hot LED for HOLD_CYCLES, then GAP_CYCLES dark.
// req->led latency 2 cycles when idle; no backpressure, repeat pulses merge into the pending bit. Define LED_SCHED_RR_EN for round-robin arbitration.
module led_event_sched #(
   parameter int          NREQ        = 4,
   parameter logic [31:0] HOLD_CYCLES = 32'd300_000_000,
   parameter logic [31:0] GAP_CYCLES  = 32'd50_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic                    clear,
   output logic [NREQ-1:0]         led,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy,
   output logic                    done,
   output logic [NREQ-1:0]         pending
);

   localparam int IDW = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [31:0]     cnt;
   logic [31:0]     cnt_nxt;
   logic [IDW-1:0]  grant_nxt;
   logic            done_nxt;
   logic [NREQ-1:0] pending_nxt;
   logic [NREQ-1:0] grant_clr;
   logic            win_vld;
   logic [IDW-1:0]  win_id;
   logic [NREQ-1:0] win_oh;

`ifdef LED_SCHED_RR_EN
   logic rr_seen;
   logic rr_seen_nxt;
   int   rr_start;

   // Two passes: indices at/after the start point first, then the wrapped-around ones.
   always_comb begin
      win_vld  = 1'b0;
      win_id   = '0;
      win_oh   = '0;
      rr_start = 0;
      if (rr_seen && (int'(grant_id) < NREQ - 1)) begin
         rr_start = int'(grant_id) + 1;
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!win_vld && pending[j] && (j >= rr_start)) begin
            win_vld   = 1'b1;
            win_id    = IDW'(j);
            win_oh[j] = 1'b1;
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!win_vld && pending[j] && (j < rr_start)) begin
            win_vld   = 1'b1;
            win_id    = IDW'(j);
            win_oh[j] = 1'b1;
         end
      end
   end
`else
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      win_oh  = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (!win_vld && pending[j]) begin
            win_vld   = 1'b1;
            win_id    = IDW'(j);
            win_oh[j] = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      grant_nxt = grant_id;
      done_nxt  = 1'b0;
      grant_clr = '0;
`ifdef LED_SCHED_RR_EN
      rr_seen_nxt = rr_seen;
`endif
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (win_vld) begin
               grant_clr = win_oh;
               grant_nxt = win_id;
               state_nxt = SHOW;
`ifdef LED_SCHED_RR_EN
               rr_seen_nxt = 1'b1;
`endif
            end
         end
         SHOW: begin
            if (cnt == HOLD_CYCLES - 32'd1) begin
               done_nxt  = 1'b1;
               cnt_nxt   = '0;
               state_nxt = (GAP_CYCLES != 32'd0) ? GAP : IDLE;
            end else begin
               cnt_nxt = cnt + 32'd1;
            end
         end
         GAP: begin
            if (cnt == GAP_CYCLES - 32'd1) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 32'd1;
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase

      // A req on the bit being granted re-arms it, so the event is shown again later.
      pending_nxt = (pending & ~grant_clr) | req;

      if (clear) begin
         state_nxt   = IDLE;
         cnt_nxt     = '0;
         done_nxt    = 1'b0;
         pending_nxt = '0;
         grant_nxt   = grant_id;
`ifdef LED_SCHED_RR_EN
         rr_seen_nxt = rr_seen;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         grant_id <= '0;
         done     <= 1'b0;
         pending  <= '0;
`ifdef LED_SCHED_RR_EN
         rr_seen  <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         grant_id <= grant_nxt;
         done     <= done_nxt;
         pending  <= pending_nxt;
`ifdef LED_SCHED_RR_EN
         rr_seen  <= rr_seen_nxt;
`endif
      end
   end

   always_comb begin
      led = '0;
      if (state == SHOW) begin
         for (int j = 0; j < NREQ; j++) begin
            led[j] = (grant_id == IDW'(j));
         end
      end
   end

   assign busy = (state == SHOW) || (state == GAP);

endmodule

// File: tb/tb_led_event_sched.sv
// Bench for led_event_sched: timeline-based reference model (show start time + hold/gap arithmetic) plus directed spot checks.
module tb_led_event_sched;

   localparam int NREQ = 4;
   localparam int HOLD = 5;
   localparam int GAP  = 2;

   logic       clk   = 1'b0;
   logic       rst   = 1'b0;
   logic [3:0] req   = 4'b0;
   logic       clear = 1'b0;
   logic [3:0] led;
   logic [1:0] grant_id;
   logic       busy;
   logic       done;
   logic [3:0] pending;
   logic [11:0] obs;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: pending set, id of the latest grant, cycle its LED first lit.
   logic [3:0] m_pend;
   logic [1:0] m_id;
   int         m_s;
   bit         m_have;
`ifdef LED_SCHED_RR_EN
   int         m_rrlast;
`endif

   led_event_sched #(
      .NREQ(NREQ),
      .HOLD_CYCLES(32'd5),
      .GAP_CYCLES(32'd2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .clear(clear),
      .led(led),
      .grant_id(grant_id),
      .busy(busy),
      .done(done),
      .pending(pending)
   );

   always #5 clk = ~clk;

   assign obs = {led, grant_id, busy, done, pending};

   task automatic model_reset();
      m_pend = 4'b0;
      m_id   = 2'd0;
      m_s    = 0;
      m_have = 1'b0;
`ifdef LED_SCHED_RR_EN
      m_rrlast = NREQ - 1;
`endif
   endtask

   function automatic logic [11:0] model_out();
      logic [3:0] e_led;
      logic e_busy;
      logic e_done;
      e_led  = (m_have && cyc >= m_s && cyc < m_s + HOLD) ? (4'b0001 << m_id) : 4'b0000;
      e_done = m_have && (cyc == m_s + HOLD);
      e_busy = m_have && cyc >= m_s && cyc < m_s + HOLD + GAP;
      return {e_led, m_id, e_busy, e_done, m_pend};
   endfunction

   function automatic int pick(input logic [3:0] p);
`ifdef LED_SCHED_RR_EN
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (m_rrlast + 1 + k) % NREQ;
         if (p[i]) return i;
      end
`else
      for (int i = 0; i < NREQ; i++) begin
         if (p[i]) return i;
      end
`endif
      return 0;
   endfunction

   // Apply inputs for the current cycle, advance the model, move to the next cycle.
   task automatic drive(input logic [3:0] r, input logic c);
      bit idle;
      int w;
      req   = r;
      clear = c;
      idle  = !(m_have && cyc < m_s + HOLD + GAP);
      if (c) begin
         m_pend = 4'b0;
         m_have = 1'b0;
      end else begin
         if (idle && m_pend != 4'b0) begin
            w      = pick(m_pend);
            m_id   = 2'(w);
            m_s    = cyc + 1;
            m_have = 1'b1;
            m_pend = m_pend & ~(4'b0001 << w);
`ifdef LED_SCHED_RR_EN
            m_rrlast = w;
`endif
         end
         m_pend = m_pend | r;
      end
      @(posedge clk);
      #1;
      cyc++;
      req   = 4'b0;
      clear = 1'b0;
   endtask

   task automatic test_reset();
      total++;
      if (obs !== 12'h000) begin
         bad++;
         $display("FAIL reset_outputs got=%h exp=%h", obs, 12'h000);
      end
      total++;
      if (obs !== model_out()) begin
         bad++;
         $display("FAIL reset_model got=%h exp=%h", obs, model_out());
      end
   endtask

   task automatic test_single();
      int t0, k;
      t0 = cyc;
      drive(4'b0100, 1'b0);
      for (int n = 0; n < 10; n++) begin
         k = cyc - t0;
         total++;
         if (obs !== model_out()) begin
            bad++;
            $display("FAIL single_model k=%0d got=%h exp=%h", k, obs, model_out());
         end
         total++;
         if (led !== ((k >= 2 && k <= 6) ? 4'b0100 : 4'b0000)) begin
            bad++;
            $display("FAIL single_led k=%0d got=%b", k, led);
         end
         total++;
         if (done !== (k == 7) || busy !== (k >= 2 && k <= 8)) begin
            bad++;
            $display("FAIL single_done_busy k=%0d got done=%b busy=%b", k, done, busy);
         end
         if (k >= 2) begin
            total++;
            if (grant_id !== 2'd2) begin
               bad++;
               $display("FAIL single_grant k=%0d got=%0d exp=2", k, grant_id);
            end
         end
         drive(4'b0000, 1'b0);
      end
   endtask

   task automatic test_simultaneous();
      int t0, k;
      logic [3:0] first, second;
`ifdef LED_SCHED_RR_EN
      first  = 4'b1000;
      second = 4'b0010;
`else
      first  = 4'b0010;
      second = 4'b1000;
`endif
      t0 = cyc;
      drive(4'b1010, 1'b0);
      for (int n = 0; n < 20; n++) begin
         k = cyc - t0;
         total++;
         if (obs !== model_out()) begin
            bad++;
            $display("FAIL simul_model k=%0d got=%h exp=%h", k, obs, model_out());
         end
         if (k == 2 || k == 10) begin
            total++;
            if (led !== ((k == 2) ? first : second)) begin
               bad++;
               $display("FAIL simul_order k=%0d got=%b exp=%b", k, led, (k == 2) ? first : second);
            end
         end
         drive(4'b0000, 1'b0);
      end
   endtask

   task automatic test_rerequest();
      int t0, k;
      t0 = cyc;
      drive(4'b0010, 1'b0);
      for (int n = 0; n < 20; n++) begin
         k = cyc - t0;
         total++;
         if (obs !== model_out()) begin
            bad++;
            $display("FAIL rereq_model k=%0d got=%h exp=%h", k, obs, model_out());
         end
         if (k == 7 || k == 8) begin
            total++;
            if (pending[1] !== 1'b1 || busy !== 1'b1) begin
               bad++;
               $display("FAIL rereq_gap_pending k=%0d got pending=%b busy=%b", k, pending, busy);
            end
         end
         if (k == 10 || k == 14) begin
            total++;
            if (led !== 4'b0010) begin
               bad++;
               $display("FAIL rereq_reshow k=%0d got=%b exp=0010", k, led);
            end
         end
         drive((k == 3) ? 4'b0010 : 4'b0000, 1'b0);
      end
   endtask

   task automatic test_duplicate();
      int t0, k, lit, rises;
      logic [3:0] prev;
      t0    = cyc;
      lit   = 0;
      rises = 0;
      prev  = 4'b0;
      drive(4'b0001, 1'b0);
      for (int n = 0; n < 30; n++) begin
         k = cyc - t0;
         total++;
         if (obs !== model_out()) begin
            bad++;
            $display("FAIL dup_model k=%0d got=%h exp=%h", k, obs, model_out());
         end
         if (led == 4'b1000) lit++;
         if (led == 4'b1000 && prev != 4'b1000) rises++;
         prev = led;
         drive((k == 3 || k == 5 || k == 7) ? 4'b1000 : 4'b0000, 1'b0);
      end
      total++;
      if (lit != HOLD || rises != 1) begin
         bad++;
         $display("FAIL dup_once got lit=%0d rises=%0d exp lit=%0d rises=1", lit, rises, HOLD);
      end
   endtask

   task automatic test_clear();
      int t0, k;
      logic [3:0] r;
      logic c;
      t0 = cyc;
      drive(4'b0100, 1'b0);
      for (int n = 0; n < 14; n++) begin
         k = cyc - t0;
         total++;
         if (obs !== model_out()) begin
            bad++;
            $display("FAIL clear_model k=%0d got=%h exp=%h", k, obs, model_out());
         end
         if (k == 4) begin
            total++;
            if (led !== 4'b0100 || pending !== 4'b0001) begin
               bad++;
               $display("FAIL clear_setup got led=%b pending=%b exp led=0100 pending=0001", led, pending);
            end
         end
         if (k == 5) begin
            total++;
            if ({led, pending, busy} !== 9'b0 || grant_id !== 2'd2) begin
               bad++;
               $display("FAIL clear_flush got led=%b pending=%b busy=%b grant=%0d", led, pending, busy, grant_id);
            end
         end
         if (k >= 5 && k <= 8) begin
            total++;
            if (done !== 1'b0) begin
               bad++;
               $display("FAIL clear_no_done k=%0d got=%b exp=0", k, done);
            end
         end
         if (k == 9) begin
            total++;
            if (led !== 4'b1000) begin
               bad++;
               $display("FAIL clear_resume got=%b exp=1000", led);
            end
         end
         r = (k == 3) ? 4'b0001 : (k == 4) ? 4'b0010 : (k == 7) ? 4'b1000 : 4'b0000;
         c = (k == 4);
         drive(r, c);
      end
   endtask

   task automatic test_async_reset();
      int t0, k;
      repeat (8) drive(4'b0000, 1'b0);
      t0 = cyc;
      drive(4'b0100, 1'b0);
      repeat (4) drive(4'b0000, 1'b0);
      total++;
      if (led !== 4'b0100 || busy !== 1'b1) begin
         bad++;
         $display("FAIL areset_setup got led=%b busy=%b", led, busy);
      end
      #3 rst = 1'b0;
      #1;
      total++;
      if (obs !== 12'h000) begin
         bad++;
         $display("FAIL areset_immediate got=%h exp=%h", obs, 12'h000);
      end
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      model_reset();
      total++;
      if (obs !== model_out()) begin
         bad++;
         $display("FAIL areset_release got=%h exp=%h", obs, model_out());
      end
      t0 = cyc;
      drive(4'b0001, 1'b0);
      for (int n = 0; n < 10; n++) begin
         k = cyc - t0;
         total++;
         if (obs !== model_out()) begin
            bad++;
            $display("FAIL areset_resume k=%0d got=%h exp=%h", k, obs, model_out());
         end
         if (k == 2) begin
            total++;
            if (led !== 4'b0001) begin
               bad++;
               $display("FAIL areset_led got=%b exp=0001", led);
            end
         end
         drive(4'b0000, 1'b0);
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      logic c;
      for (int n = 0; n < 400; n++) begin
         total++;
         if (obs !== model_out()) begin
            bad++;
            $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, obs, model_out());
         end
         r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         c = ($urandom_range(0, 59) == 0);
         drive(r, c);
      end
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      test_reset();
      test_single();
      test_simultaneous();
      test_rerequest();
      test_duplicate();
      test_clear();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
